// File: rtl/cpu_types_pkg.sv
// Shared CPU bus types: RAM handshake state and the 32-bit machine word.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Cache-side and RAM-side signals of the memory arbiter; slave is the arbiter's view.
interface memory_arbiter_if;
  import cpu_types_pkg::*;

  logic      iREN;
  word_t     iaddr;
  logic      iwait;
  word_t     iload;
  logic      dREN;
  logic      dWEN;
  word_t     daddr;
  word_t     dstore;
  logic      dwait;
  word_t     dload;
  logic      ramREN;
  logic      ramWEN;
  word_t     ramaddr;
  word_t     ramstore;
  word_t     ramload;
  ramstate_t ramstate;
  logic      ramerr;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ramerr
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, ramerr
  );

endinterface

// File: rtl/memory_arbiter.sv
// Arbitrates icache/dcache word requests onto a single-ported RAM, dcache first.
// Define MEMARB_STARVE_EN to force an icache grant after STARVE_LIMIT back-to-back dcache grants.
module memory_arbiter
  import cpu_types_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic                    CLK,
  input logic                    nRST,
  memory_arbiter_if.slave        bus
);

  typedef enum logic [1:0] {StIdle, StDGnt, StIGnt} arb_state_t;

  arb_state_t state;
  word_t      addr_q;
  word_t      store_q;
  logic       ren_q;
  logic       wen_q;
  logic       err_q;

  logic d_req;
  logic force_i;
  logic grant_d;
  logic grant_i;
  logic ram_done;

  assign d_req    = bus.dREN | bus.dWEN;
  assign ram_done = (bus.ramstate == ACCESS) || (bus.ramstate == ERROR);

`ifdef MEMARB_STARVE_EN
  logic [2:0] starve_q;

  assign force_i = (starve_q == 3'(STARVE_LIMIT)) && bus.iREN;

  // Counts consecutive dcache grants taken while the icache was left waiting.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      starve_q <= '0;
    end else if (state == StIdle) begin
      if (grant_d) begin
        starve_q <= bus.iREN ? starve_q + 3'd1 : 3'd0;
      end else if (grant_i) begin
        starve_q <= '0;
      end
    end
  end
`else
  assign force_i = 1'b0;
`endif

  assign grant_d = d_req && !force_i;
  assign grant_i = bus.iREN && !grant_d;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= StIdle;
      addr_q  <= '0;
      store_q <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (grant_d) begin
            state   <= StDGnt;
            addr_q  <= bus.daddr;
            store_q <= bus.dstore;
            wen_q   <= bus.dWEN;
            ren_q   <= !bus.dWEN;
          end else if (grant_i) begin
            state  <= StIGnt;
            addr_q <= bus.iaddr;
            wen_q  <= 1'b0;
            ren_q  <= 1'b1;
          end
        end
        StDGnt: begin
          // A dropped request aborts; otherwise hold until RAM finishes.
          if (!d_req || ram_done) begin
            state <= StIdle;
            ren_q <= 1'b0;
            wen_q <= 1'b0;
          end
          if (d_req && bus.ramstate == ERROR) err_q <= 1'b1;
        end
        StIGnt: begin
          if (!bus.iREN || ram_done) begin
            state <= StIdle;
            ren_q <= 1'b0;
            wen_q <= 1'b0;
          end
          if (bus.iREN && bus.ramstate == ERROR) err_q <= 1'b1;
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.ramaddr  = addr_q;
  assign bus.ramstore = store_q;
  assign bus.ramerr   = err_q;

  // Wait/load respond to ramstate in the same cycle; enables drop as soon as a requester aborts.
  always_comb begin
    bus.dwait  = 1'b1;
    bus.iwait  = 1'b1;
    bus.dload  = '0;
    bus.iload  = '0;
    bus.ramREN = 1'b0;
    bus.ramWEN = 1'b0;
    unique case (state)
      StDGnt: begin
        if (d_req) begin
          bus.ramREN = ren_q;
          bus.ramWEN = wen_q;
          if (bus.ramstate == ACCESS) begin
            bus.dwait = 1'b0;
            bus.dload = wen_q ? '0 : bus.ramload;
          end else if (bus.ramstate == ERROR) begin
            bus.dwait = 1'b0;
          end
        end
      end
      StIGnt: begin
        if (bus.iREN) begin
          bus.ramREN = ren_q;
          if (bus.ramstate == ACCESS) begin
            bus.iwait = 1'b0;
            bus.iload = bus.ramload;
          end else if (bus.ramstate == ERROR) begin
            bus.iwait = 1'b0;
          end
        end
      end
      default: ;
    endcase
  end

endmodule
